mem_cmd_ram: RTL and testbench

MEM_CMD_RAM -- requirements
Module: mem_cmd_ram

---
 rtl/mem_cmd_ram.sv | 195 +++++++++++++++++++
 tb/tb_mem_cmd_ram.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_cmd_ram.sv
`default_nettype none
// ============================================================================
// Module   : mem_cmd_ram
// Purpose  : Single-port 32-bit RAM behind a valid/ready command interface.
//            Writes are performed at the acceptance edge. Reads return one
//            registered response strobe after WAIT_STATES extra cycles.
//            Accesses outside the BASE_ADDR window are trapped: writes are
//            dropped, reads return zero, and the first offending address is
//            captured in a sticky error register.
// Ports    : clk            - single clock, rising edge
//            reset_         - asynchronous active-low reset
//            mem_cmd_valid  - command request
//            mem_cmd_ready  - command accepted when valid && ready at an edge
//            mem_cmd_instr  - instruction-fetch tag (counted only)
//            mem_cmd_wr     - 1 = write, 0 = read
//            mem_cmd_addr   - byte address, bits [1:0] ignored
//            mem_cmd_wdata  - write data
//            mem_cmd_be     - write byte enables
//            mem_rsp_ready  - one-cycle read-response strobe
//            mem_rsp_rdata  - read data, valid with mem_rsp_ready
//            err_addr       - sticky out-of-window flag
//            err_addr_val   - byte address of first out-of-window access
// Revision : 1.0 - initial release
// ============================================================================
module mem_cmd_ram #(
  parameter int unsigned ADDR_BITS   = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        mem_cmd_valid,
  output logic        mem_cmd_ready,
  input  logic        mem_cmd_instr,
  input  logic        mem_cmd_wr,
  input  logic [31:0] mem_cmd_addr,
  input  logic [31:0] mem_cmd_wdata,
  input  logic [3:0]  mem_cmd_be,
  output logic        mem_rsp_ready,
  output logic [31:0] mem_rsp_rdata,
  output logic        err_addr,
  output logic [31:0] err_addr_val
);

  localparam int unsigned c_depth = 1 << ADDR_BITS;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_wait = 2'd1;
  localparam logic [1:0] c_st_rsp  = 2'd2;

  // Counter preload; the WAIT state lasts c_wait_load+1 cycles.
  localparam logic [3:0] c_wait_load = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

  logic [1:0]           state_q,        state_d;
  logic [3:0]           wait_cnt_q,     wait_cnt_d;
  logic [ADDR_BITS-1:0] addr_q,         addr_d;
  logic                 oow_q,          oow_d;
  logic                 rsp_ready_q,    rsp_ready_d;
  logic [31:0]          rsp_rdata_q,    rsp_rdata_d;
  logic                 err_addr_q,     err_addr_d;
  logic [31:0]          err_addr_val_q, err_addr_val_d;
  logic [31:0]          instr_cnt_q,    instr_cnt_d;

  logic [31:0] mem [c_depth];

  logic                 w_accept;
  logic [ADDR_BITS-1:0] w_cmd_idx;
  logic                 w_cmd_oow;
  logic                 w_is_write;
  logic                 w_wr_en;
  logic                 w_rd_accept;
  logic [ADDR_BITS-1:0] w_rd_idx;
  logic                 w_rd_oow;
  logic [31:0]          w_rd_word;
  logic                 w_unused;

  // Ready depends on state alone so the initiator sees no combinational
  // path from its own valid.
  assign mem_cmd_ready = (state_q == c_st_idle);

  assign w_accept    = mem_cmd_valid && (state_q == c_st_idle);
  assign w_cmd_idx   = mem_cmd_addr[ADDR_BITS+1:2];
  assign w_cmd_oow   = (mem_cmd_addr[31:ADDR_BITS+2] != BASE_ADDR[31:ADDR_BITS+2]);
  // A write with no byte enables carries no data and is serviced as a read.
  assign w_is_write  = mem_cmd_wr && (mem_cmd_be != 4'b0000);
  assign w_wr_en     = w_accept && w_is_write && !w_cmd_oow;
  assign w_rd_accept = w_accept && !w_is_write;

  // With zero wait states the response is loaded at the acceptance edge,
  // so the lookup must use the live command address; otherwise the address
  // latched at acceptance is used. No write can be accepted in between.
  assign w_rd_idx  = (state_q == c_st_idle) ? w_cmd_idx : addr_q;
  assign w_rd_oow  = (state_q == c_st_idle) ? w_cmd_oow : oow_q;
  assign w_rd_word = w_rd_oow ? 32'h0000_0000 : mem[w_rd_idx];

  // Byte-offset bits of the address carry no information for a word RAM.
  assign w_unused = ^mem_cmd_addr[1:0];

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    addr_d         = addr_q;
    oow_d          = oow_q;
    rsp_ready_d    = 1'b0;
    rsp_rdata_d    = rsp_rdata_q;
    err_addr_d     = err_addr_q;
    err_addr_val_d = err_addr_val_q;
    instr_cnt_d    = instr_cnt_q;

    case (state_q)
      c_st_idle: begin
        if (w_rd_accept) begin
          addr_d = w_cmd_idx;
          oow_d  = w_cmd_oow;
          if (WAIT_STATES == 0) begin
            state_d     = c_st_rsp;
            rsp_ready_d = 1'b1;
            rsp_rdata_d = w_rd_word;
          end else begin
            state_d    = c_st_wait;
            wait_cnt_d = c_wait_load;
          end
        end
      end
      c_st_wait: begin
        if (wait_cnt_q == 4'd0) begin
          state_d     = c_st_rsp;
          rsp_ready_d = 1'b1;
          rsp_rdata_d = w_rd_word;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      c_st_rsp: begin
        state_d = c_st_idle;
      end
      default: begin
        state_d = c_st_idle;
      end
    endcase

    // Only the first out-of-window access is recorded.
    if (w_accept && w_cmd_oow && !err_addr_q) begin
      err_addr_d     = 1'b1;
      err_addr_val_d = mem_cmd_addr;
    end

    // Instruction-fetch count, observable through hierarchy for debug.
    if (w_accept && mem_cmd_instr) begin
      instr_cnt_d = instr_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q        <= c_st_idle;
      wait_cnt_q     <= 4'd0;
      addr_q         <= '0;
      oow_q          <= 1'b0;
      rsp_ready_q    <= 1'b0;
      rsp_rdata_q    <= 32'h0000_0000;
      err_addr_q     <= 1'b0;
      err_addr_val_q <= 32'h0000_0000;
      instr_cnt_q    <= 32'd0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      addr_q         <= addr_d;
      oow_q          <= oow_d;
      rsp_ready_q    <= rsp_ready_d;
      rsp_rdata_q    <= rsp_rdata_d;
      err_addr_q     <= err_addr_d;
      err_addr_val_q <= err_addr_val_d;
      instr_cnt_q    <= instr_cnt_d;
    end
  end

  // RAM array has no reset so its contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_cmd_be[b]) begin
          mem[w_cmd_idx][8*b +: 8] <= mem_cmd_wdata[8*b +: 8];
        end
      end
    end
  end

  assign mem_rsp_ready = rsp_ready_q;
  assign mem_rsp_rdata = rsp_rdata_q;
  assign err_addr      = err_addr_q;
  assign err_addr_val  = err_addr_val_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_cmd_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_cmd_ram
// Purpose  : Self-checking bench for mem_cmd_ram. Three instances with
//            WAIT_STATES 0, 3 and 5 share the command bus; each has its own
//            valid and reset. Directed vector table, hand sequences for wait
//            states and mid-read reset, and a randomized mix against a
//            word-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_cmd_ram;

  logic        clk = 1'b0;
  logic [2:0]  rstn;
  logic [2:0]  valid;
  logic [2:0]  rdy;
  logic [2:0]  rsp;
  logic [2:0]  err;
  logic        instr;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdat0, rdat1, rdat2;
  logic [31:0] errv0, errv1, errv2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_cmd_ram #(.ADDR_BITS(10), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset_(rstn[0]), .mem_cmd_valid(valid[0]), .mem_cmd_ready(rdy[0]),
    .mem_cmd_instr(instr), .mem_cmd_wr(wr), .mem_cmd_addr(addr), .mem_cmd_wdata(wdata),
    .mem_cmd_be(be), .mem_rsp_ready(rsp[0]), .mem_rsp_rdata(rdat0),
    .err_addr(err[0]), .err_addr_val(errv0));

  mem_cmd_ram #(.ADDR_BITS(10), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u_dut1 (
    .clk(clk), .reset_(rstn[1]), .mem_cmd_valid(valid[1]), .mem_cmd_ready(rdy[1]),
    .mem_cmd_instr(instr), .mem_cmd_wr(wr), .mem_cmd_addr(addr), .mem_cmd_wdata(wdata),
    .mem_cmd_be(be), .mem_rsp_ready(rsp[1]), .mem_rsp_rdata(rdat1),
    .err_addr(err[1]), .err_addr_val(errv1));

  mem_cmd_ram #(.ADDR_BITS(10), .BASE_ADDR(32'h0), .WAIT_STATES(5)) u_dut2 (
    .clk(clk), .reset_(rstn[2]), .mem_cmd_valid(valid[2]), .mem_cmd_ready(rdy[2]),
    .mem_cmd_instr(instr), .mem_cmd_wr(wr), .mem_cmd_addr(addr), .mem_cmd_wdata(wdata),
    .mem_cmd_be(be), .mem_rsp_ready(rsp[2]), .mem_rsp_rdata(rdat2),
    .err_addr(err[2]), .err_addr_val(errv2));

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tab[16];

  // Reference model for the random phase: 16 words at byte 0x100.
  logic [31:0] model [16];

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 3 : 5);
  endfunction

  function automatic logic [31:0] rdat_of(input int d);
    return (d == 0) ? rdat0 : ((d == 1) ? rdat1 : rdat2);
  endfunction

  function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] dt,
                              input logic [3:0] b, input logic [31:0] e, input string n);
    vec_t v;
    v.wr = w; v.addr = a; v.wdata = dt; v.be = b; v.exp = e; v.name = n;
    return v;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++)
      if (b[k]) r[8*k +: 8] = nw[8*k +: 8];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one command to instance d. Called at a negedge (or after #1 past a
  // posedge) while that instance is idle; returns at a negedge with the
  // instance idle again. Reads are checked cycle by cycle for strobe timing,
  // ready, and data. With noise set, valid stays high with write traffic to
  // the same address while the read is outstanding.
  task automatic cmd(input int d, input logic c_wr, input logic [31:0] c_addr,
                     input logic [31:0] c_wdata, input logic [3:0] c_be,
                     input logic [31:0] exp, input bit noise, input string nm);
    int  ws;
    bit  is_rd;
    ws    = ws_of(d);
    is_rd = !(c_wr && (c_be != 4'b0000));
    wr = c_wr; addr = c_addr; wdata = c_wdata; be = c_be;
    instr = 1'($urandom);
    valid[d] = 1'b1;
    @(posedge clk); #1;
    valid[d] = noise && is_rd;
    wr    = noise ? 1'b1 : 1'($urandom);
    addr  = noise ? c_addr : $urandom;
    wdata = $urandom;
    be    = noise ? 4'hF : 4'($urandom);
    if (!is_rd) begin
      @(negedge clk);
      chk($sformatf("%s wr_rsp", nm), {31'd0, rsp[d]}, 32'd0);
      chk($sformatf("%s wr_rdy", nm), {31'd0, rdy[d]}, 32'd1);
    end else begin
      for (int i = 1; i <= ws + 2; i++) begin
        @(negedge clk);
        chk($sformatf("%s rsp@%0d", nm, i), {31'd0, rsp[d]}, {31'd0, (i == ws + 1)});
        chk($sformatf("%s rdy@%0d", nm, i), {31'd0, rdy[d]}, {31'd0, (i == ws + 2)});
        if (i >= ws + 1) chk($sformatf("%s rdata@%0d", nm, i), rdat_of(d), exp);
        if (i == ws + 1) valid[d] = 1'b0;
      end
    end
  endtask

  initial begin
    logic [31:0] a, dt, e;
    logic [3:0]  b;
    logic        w, oow;
    int          idx;

    tab[0]  = mk(1, 32'h0000_0010, 32'hCAFE_BABE, 4'hF, 32'h0,         "wr10");
    tab[1]  = mk(0, 32'h0000_0010, 32'h0,         4'h0, 32'hCAFE_BABE, "rd10");
    tab[2]  = mk(1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0,         "pre20");
    tab[3]  = mk(1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'h0,         "lane20");
    tab[4]  = mk(0, 32'h0000_0020, 32'h0,         4'h0, 32'h11BB_33DD, "rd20");
    tab[5]  = mk(1, 32'h0000_0000, 32'h5A5A_0001, 4'hF, 32'h0,         "wr0");
    tab[6]  = mk(1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 32'h0,         "oow_wr");
    tab[7]  = mk(0, 32'h0000_1000, 32'h0,         4'h0, 32'h0,         "oow_rd");
    tab[8]  = mk(0, 32'h0000_0000, 32'h0,         4'h0, 32'h5A5A_0001, "rd0");
    tab[9]  = mk(1, 32'h0000_0024, 32'h0BAD_F00D, 4'hF, 32'h0,         "wr24");
    tab[10] = mk(1, 32'h0000_0024, 32'hFFFF_FFFF, 4'h0, 32'h0BAD_F00D, "be0_as_rd");
    tab[11] = mk(0, 32'h0000_0024, 32'h0,         4'h0, 32'h0BAD_F00D, "rd24");
    tab[12] = mk(1, 32'h0000_0FFC, 32'h8765_4321, 4'hF, 32'h0,         "wrtop");
    tab[13] = mk(0, 32'h0000_0FFC, 32'h0,         4'h0, 32'h8765_4321, "rdtop");
    tab[14] = mk(0, 32'h0000_0013, 32'h0,         4'h0, 32'hCAFE_BABE, "rd_lowbits");
    tab[15] = mk(1, 32'h0000_2000, 32'h1111_1111, 4'hF, 32'h0,         "oow_wr2");

    rstn = 3'b000; valid = 3'b000; instr = 1'b0; wr = 1'b0;
    addr = 32'h0; wdata = 32'h0; be = 4'h0;

    // Reset state, sampled while reset is held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_rdy%0d", d), {31'd0, rdy[d]}, 32'd1);
      chk($sformatf("rst_rsp%0d", d), {31'd0, rsp[d]}, 32'd0);
      chk($sformatf("rst_rdata%0d", d), rdat_of(d), 32'd0);
      chk($sformatf("rst_err%0d", d), {31'd0, err[d]}, 32'd0);
    end
    chk("rst_errv0", errv0, 32'd0);
    @(posedge clk); #1;
    rstn = 3'b111;
    @(negedge clk);
    chk("post_rst_rdy0", {31'd0, rdy[0]}, 32'd1);

    // Directed vector table on the zero-wait instance.
    for (int t = 0; t < 16; t++)
      cmd(0, tab[t].wr, tab[t].addr, tab[t].wdata, tab[t].be, tab[t].exp, 1'b0, tab[t].name);
    chk("err_flag", {31'd0, err[0]}, 32'd1);
    chk("err_val_first", errv0, 32'h0000_1000);

    // Back-to-back: read of the same word on the edge after the write.
    cmd(0, 1, 32'h0000_0030, 32'h1357_9BDF, 4'hF, 32'h0, 1'b0, "b2b_wr");
    cmd(0, 0, 32'h0000_0030, 32'h0, 4'h0, 32'h1357_9BDF, 1'b0, "b2b_rd");
    cmd(0, 1, 32'h0000_0030, 32'hFFFF_0000, 4'hC, 32'h0, 1'b0, "b2b_wr2");
    cmd(0, 0, 32'h0000_0030, 32'h0, 4'h0, 32'hFFFF_9BDF, 1'b0, "b2b_rd2");

    // Three wait states, with command traffic while the read is pending.
    cmd(1, 1, 32'h0000_0040, 32'h0A0B_0C0D, 4'hF, 32'h0, 1'b0, "ws3_wr");
    cmd(1, 0, 32'h0000_0040, 32'h0, 4'h0, 32'h0A0B_0C0D, 1'b1, "ws3_rd_noise");
    cmd(1, 0, 32'h0000_0040, 32'h0, 4'h0, 32'h0A0B_0C0D, 1'b0, "ws3_rd_again");
    chk("ws3_no_err", {31'd0, err[1]}, 32'd0);

    // Five wait states, reset pulse two cycles into the read.
    cmd(2, 1, 32'h0000_0080, 32'h600D_CAFE, 4'hF, 32'h0, 1'b0, "ws5_wr");
    addr = 32'h0000_0080; wr = 1'b0; be = 4'h0; valid[2] = 1'b1;
    @(posedge clk); #1;
    valid[2] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn[2] = 1'b0;
    @(negedge clk);
    chk("midrst_rdy", {31'd0, rdy[2]}, 32'd1);
    chk("midrst_rsp", {31'd0, rsp[2]}, 32'd0);
    @(posedge clk); #1;
    rstn[2] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk($sformatf("postrst_rsp@%0d", i), {31'd0, rsp[2]}, 32'd0);
      chk($sformatf("postrst_rdy@%0d", i), {31'd0, rdy[2]}, 32'd1);
    end
    cmd(2, 0, 32'h0000_0080, 32'h0, 4'h0, 32'h600D_CAFE, 1'b0, "postrst_rd");

    // Randomized mix on the zero-wait instance.
    for (int i = 0; i < 16; i++) begin
      model[i] = $urandom;
      cmd(0, 1, 32'h100 + 32'(i * 4), model[i], 4'hF, 32'h0, 1'b0, "preload");
    end
    for (int n = 0; n < 1000; n++) begin
      idx = $urandom_range(0, 15);
      oow = ($urandom_range(0, 7) == 0);
      a   = 32'h100 + 32'(idx * 4);
      a[1:0] = 2'($urandom);
      if (oow) a[31:12] = 20'($urandom_range(1, 20'hFFFFF));
      w  = 1'($urandom);
      b  = 4'($urandom);
      dt = $urandom;
      if (w && b != 4'h0) begin
        if (!oow) model[idx] = merge(model[idx], dt, b);
        e = 32'h0;
      end else begin
        e = oow ? 32'h0 : model[idx];
      end
      cmd(0, w, a, dt, b, e, 1'b0, $sformatf("rnd%0d", n));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    chk("err_val_sticky", errv0, 32'h0000_1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
